frame_buffer_arbiter: RTL and testbench

Shares the single SDRAM controller port between the camera write path and the VGA read path in the 100 MHz domain. It drains 16-bit YCbCr words from the camera write FIFO into a circular frame buffer and refills the display read FIFO from the same buffer. Display refill takes priority when that FIFO runs low; otherwise the two paths alternate in bounded bursts. The block sits between the camera write FIFO, the display FIFO and the SDRAM controller's 68000-style bus.

---
 rtl/fb_pkg.sv | 10 +
 rtl/fb_addr_counter.sv | 47 ++++
 rtl/frame_buffer_arbiter.sv | 163 ++++++++++++++++
 tb/tb_frame_buffer_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and default sizing for the frame buffer arbiter.
package fb_pkg;

  localparam int unsigned FB_FRAME_WORDS = 172800;
  localparam int unsigned FB_BURST       = 8;

  typedef enum logic [1:0] {IDLE, WR_ACC, RD_ACC, NEXT} fb_state_t;
  typedef enum logic {GNT_WR, GNT_RD} fb_grant_t;

endpackage

// File: rtl/fb_addr_counter.sv
// Circular frame-buffer address counter with a pending start-of-frame clear
// that is only allowed to take effect between accesses.
module fb_addr_counter
  import fb_pkg::*;
#(
  parameter int unsigned W    = 24,
  parameter int unsigned WRAP = FB_FRAME_WORDS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sof,
  input  logic         apply,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt_c
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         pend_q, pend_d;

  // A pending clear beats an increment landing on the same edge.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q | sof;
    if (inc) begin
      cnt_d = (cnt_q == W'(WRAP - 1)) ? '0 : cnt_q + W'(1);
    end
    if (apply && pend_d) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign count       = cnt_q;
  assign count_nxt_c = cnt_d;

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Shares one SDRAM controller port between the camera write FIFO and the
// display read FIFO, with urgent-read priority and bounded alternating bursts.
module frame_buffer_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned FRAME_WORDS = FB_FRAME_WORDS,
  parameter int unsigned BURST       = FB_BURST,
  parameter int unsigned LVL_W       = 12,
  parameter int unsigned LOW_WATER   = 256,
  parameter int unsigned HIGH_WATER  = 3840
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_empty,
  input  logic [15:0]       wr_data,
  output logic              wr_pop,
  input  logic              wr_sof,
  input  logic [LVL_W-1:0]  rd_level,
  input  logic              rd_sof,
  output logic              rd_push,
  output logic [15:0]       rd_data,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [15:0]       dram_wdata,
  output logic              dram_sel_l,
  output logic              dram_we_l,
  input  logic [15:0]       dram_rdata,
  input  logic              dram_ack,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(BURST + 1);

  fb_state_t         state_q, state_d;
  fb_grant_t         last_q, last_d;
  logic [CNT_W-1:0]  burst_q, burst_d;
  logic              sel_l_q, sel_l_d, we_l_q, we_l_d, busy_q, busy_d, rd_push_q, rd_push_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic              wr_req, rd_urgent, rd_req, rd_more, apply, wr_inc, rd_inc, go_wr, go_rd;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nxt, rd_addr, rd_addr_nxt;

  assign wr_req    = !wr_empty;
  assign rd_urgent = rd_level < LVL_W'(LOW_WATER);
  assign rd_req    = rd_level < LVL_W'(HIGH_WATER);
  assign rd_more   = rd_level < LVL_W'(HIGH_WATER - 1);
  assign apply     = (state_q == IDLE) || (state_q == NEXT);

  fb_addr_counter #(.W(ADDR_W), .WRAP(FRAME_WORDS)) u_wr_cnt (
    .clk(clk), .reset(reset), .sof(wr_sof), .apply(apply), .inc(wr_inc),
    .count(wr_addr), .count_nxt_c(wr_addr_nxt)
  );

  fb_addr_counter #(.W(ADDR_W), .WRAP(FRAME_WORDS)) u_rd_cnt (
    .clk(clk), .reset(reset), .sof(rd_sof), .apply(apply), .inc(rd_inc),
    .count(rd_addr), .count_nxt_c(rd_addr_nxt)
  );

  // Next-state and registered bus outputs; bus fields hold unless changed.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    burst_d   = burst_q;
    sel_l_d   = sel_l_q;
    we_l_d    = we_l_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    rd_push_d = 1'b0;
    wr_inc    = 1'b0;
    rd_inc    = 1'b0;
    go_wr     = 1'b0;
    go_rd     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_urgent)              go_rd = 1'b1;
        else if (wr_req && rd_req)  begin go_wr = (last_q == GNT_RD); go_rd = (last_q == GNT_WR); end
        else if (wr_req)            go_wr = 1'b1;
        else if (rd_req)            go_rd = 1'b1;
        if (go_wr || go_rd) begin
          last_d  = go_wr ? GNT_WR : GNT_RD;
          burst_d = '0;
        end
      end
      WR_ACC: begin
        if (dram_ack) begin
          wr_inc  = 1'b1;
          burst_d = burst_q + CNT_W'(1);
          sel_l_d = 1'b1;
          we_l_d  = 1'b1;
          state_d = NEXT;
        end
      end
      RD_ACC: begin
        if (dram_ack) begin
          rd_inc    = 1'b1;
          burst_d   = burst_q + CNT_W'(1);
          rd_data_d = dram_rdata;
          rd_push_d = 1'b1;
          sel_l_d   = 1'b1;
          state_d   = NEXT;
        end
      end
      NEXT: begin
        if (burst_q < CNT_W'(BURST) && last_q == GNT_WR && wr_req)       go_wr = 1'b1;
        else if (burst_q < CNT_W'(BURST) && last_q == GNT_RD && rd_more) go_rd = 1'b1;
        else                                                             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Launch addresses from the counters' next value so an SOF clear applies now.
    if (go_wr) begin
      state_d = WR_ACC;
      sel_l_d = 1'b0;
      we_l_d  = 1'b0;
      addr_d  = wr_addr_nxt;
      wdata_d = wr_data;
    end else if (go_rd) begin
      state_d = RD_ACC;
      sel_l_d = 1'b0;
      we_l_d  = 1'b1;
      addr_d  = rd_addr_nxt;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= GNT_RD;
      burst_q   <= '0;
      sel_l_q   <= 1'b1;
      we_l_q    <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      rd_push_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      sel_l_q   <= sel_l_d;
      we_l_q    <= we_l_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      rd_push_q <= rd_push_d;
      busy_q    <= busy_d;
    end
  end

  // The pop rides on the ack so the show-ahead head is fresh by NEXT.
  assign wr_pop     = !reset && (state_q == WR_ACC) && dram_ack;
  assign rd_push    = rd_push_q;
  assign rd_data    = rd_data_q;
  assign dram_addr  = addr_q;
  assign dram_wdata = wdata_q;
  assign dram_sel_l = sel_l_q;
  assign dram_we_l  = we_l_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a camera FIFO model and an SDRAM responder.
module tb_frame_buffer_arbiter;

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned FW      = 12;
  localparam int unsigned LVL_W   = 12;
  localparam int          ACK_LAT = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_empty, wr_pop, wr_sof = 1'b0, rd_sof = 1'b0, rd_push;
  logic [15:0]       wr_data, rd_data, dram_wdata, dram_rdata;
  logic [LVL_W-1:0]  rd_level = 12'd4000;
  logic [ADDR_W-1:0] dram_addr;
  logic              dram_sel_l, dram_we_l, dram_ack, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  frame_buffer_arbiter #(
    .ADDR_W(ADDR_W), .FRAME_WORDS(FW), .BURST(8), .LVL_W(LVL_W),
    .LOW_WATER(256), .HIGH_WATER(3840)
  ) dut (
    .clk(clk), .reset(reset), .wr_empty(wr_empty), .wr_data(wr_data), .wr_pop(wr_pop),
    .wr_sof(wr_sof), .rd_level(rd_level), .rd_sof(rd_sof), .rd_push(rd_push), .rd_data(rd_data),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_sel_l(dram_sel_l), .dram_we_l(dram_we_l),
    .dram_rdata(dram_rdata), .dram_ack(dram_ack), .busy(busy)
  );

  // Show-ahead camera FIFO
  logic [15:0] cam_mem [0:63];
  int cam_head = 0;
  int cam_tail = 0;
  int pop_cnt  = 0;
  assign wr_empty = (cam_head == cam_tail);
  assign wr_data  = cam_mem[cam_head[5:0]];
  always @(posedge clk) if (wr_pop) begin cam_head <= cam_head + 1; pop_cnt <= pop_cnt + 1; end

  // SDRAM responder: ack ACK_LAT cycles after select, read data = A000 | addr[11:0]
  int lat_cnt = 0;
  initial begin dram_ack = 1'b0; dram_rdata = 16'h0; end
  always @(posedge clk) begin
    dram_ack <= 1'b0;
    if (reset) lat_cnt <= 0;
    else if (!dram_sel_l && !dram_ack) begin
      if (lat_cnt == ACK_LAT - 1) begin
        dram_ack   <= 1'b1;
        dram_rdata <= 16'hA000 | 16'(dram_addr[11:0]);
        lat_cnt    <= 0;
      end else lat_cnt <= lat_cnt + 1;
    end else lat_cnt <= 0;
  end

  // Access and push logs
  int                acc_n = 0;
  int                push_n = 0;
  int                idle_cnt = 0;
  logic [ADDR_W-1:0] acc_addr [0:255];
  logic              acc_we   [0:255];
  logic [15:0]       acc_wd   [0:255];
  int                acc_idle [0:255];
  logic [15:0]       push_data [0:255];
  always @(posedge clk) begin
    if (!busy) idle_cnt <= idle_cnt + 1;
    if (!reset && dram_ack && !dram_sel_l) begin
      acc_addr[acc_n[7:0]] <= dram_addr;
      acc_we[acc_n[7:0]]   <= dram_we_l;
      acc_wd[acc_n[7:0]]   <= dram_wdata;
      acc_idle[acc_n[7:0]] <= idle_cnt;
      acc_n <= acc_n + 1;
    end
    if (rd_push) begin push_data[push_n[7:0]] <= rd_data; push_n <= push_n + 1; end
  end

  task automatic push_word(input logic [15:0] w);
    cam_mem[cam_tail[5:0]] = w;
    cam_tail++;
  endtask

  task automatic wait_acc(input int target);
    int k = 0;
    while (acc_n < target && k < 300) begin @(negedge clk); k++; end
    n_tests++;
    if (acc_n < target) begin n_fail++; $display("FAIL wait_acc: got %0d accesses want %0d", acc_n, target); end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < 300) begin @(negedge clk); k++; end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL wait_idle: busy got %b want 0", busy); end
  endtask

  task automatic wait_sel();
    int k = 0;
    while (dram_sel_l !== 1'b0 && k < 300) begin @(negedge clk); k++; end
    n_tests++;
    if (dram_sel_l !== 1'b0) begin n_fail++; $display("FAIL wait_sel: sel_l got %b want 0", dram_sel_l); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests += 8;
    if (dram_sel_l !== 1'b1) begin n_fail++; $display("FAIL reset_sel_l: got %b want 1", dram_sel_l); end
    if (dram_we_l !== 1'b1) begin n_fail++; $display("FAIL reset_we_l: got %b want 1", dram_we_l); end
    if (dram_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", dram_addr); end
    if (dram_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", dram_wdata); end
    if (rd_data !== 16'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    if (rd_push !== 1'b0) begin n_fail++; $display("FAIL reset_rd_push: got %b want 0", rd_push); end
    if (wr_pop !== 1'b0) begin n_fail++; $display("FAIL reset_wr_pop: got %b want 0", wr_pop); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_only();
    int base = acc_n;
    int pb = pop_cnt;
    int rb = push_n;
    logic [15:0] w [0:2];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
    rd_level = 12'd4000;
    for (int i = 0; i < 3; i++) push_word(w[i]);
    @(negedge clk);
    n_tests += 2;
    if (dram_sel_l !== 1'b0) begin n_fail++; $display("FAIL wo_grant_latency: sel_l got %b want 0", dram_sel_l); end
    if (dram_we_l !== 1'b0) begin n_fail++; $display("FAIL wo_first_we_l: got %b want 0", dram_we_l); end
    wait_acc(base + 3);
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      n_tests += 3;
      if (acc_addr[base+i] !== ADDR_W'(i)) begin n_fail++; $display("FAIL wo_addr[%0d]: got %0d want %0d", i, acc_addr[base+i], i); end
      if (acc_we[base+i] !== 1'b0) begin n_fail++; $display("FAIL wo_we_l[%0d]: got %b want 0", i, acc_we[base+i]); end
      if (acc_wd[base+i] !== w[i]) begin n_fail++; $display("FAIL wo_wdata[%0d]: got %h want %h", i, acc_wd[base+i], w[i]); end
    end
    n_tests += 2;
    if (pop_cnt - pb != 3) begin n_fail++; $display("FAIL wo_pops: got %0d want 3", pop_cnt - pb); end
    if (push_n != rb) begin n_fail++; $display("FAIL wo_no_push: got %0d want 0", push_n - rb); end
  endtask

  // SOF while idle zeroes the write pointer; 14 words give a capped burst of 8 then 6, wrapping at 12.
  task automatic test_burst();
    int base;
    int pb = pop_cnt;
    @(negedge clk) wr_sof = 1'b1;
    @(negedge clk) wr_sof = 1'b0;
    base = acc_n;
    for (int i = 0; i < 14; i++) push_word(16'h4000 + 16'(i));
    wait_acc(base + 14);
    wait_idle();
    for (int i = 0; i < 14; i++) begin
      n_tests += 2;
      if (acc_addr[base+i] !== ADDR_W'(i % FW)) begin n_fail++; $display("FAIL burst_addr[%0d]: got %0d want %0d", i, acc_addr[base+i], i % FW); end
      if (acc_wd[base+i] !== 16'h4000 + 16'(i)) begin n_fail++; $display("FAIL burst_wdata[%0d]: got %h want %h", i, acc_wd[base+i], 16'h4000 + 16'(i)); end
    end
    n_tests += 3;
    if (acc_idle[base+7] != acc_idle[base]) begin n_fail++; $display("FAIL burst_no_gap: idle cycles got %0d want 0", acc_idle[base+7] - acc_idle[base]); end
    if (acc_idle[base+8] <= acc_idle[base+7]) begin n_fail++; $display("FAIL burst_gap: idle cycles got %0d want >=1", acc_idle[base+8] - acc_idle[base+7]); end
    if (pop_cnt - pb != 14) begin n_fail++; $display("FAIL burst_pops: got %0d want 14", pop_cnt - pb); end
  endtask

  // After reset both request: write burst first, then read burst, then the rest of the writes.
  task automatic test_alternate();
    int base;
    int rb;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = acc_n;
    rb = push_n;
    for (int i = 0; i < 10; i++) push_word(16'h6000 + 16'(i));
    rd_level = 12'd1000;
    wait_acc(base + 18);
    rd_level = 12'd4000;
    wait_idle();
    for (int i = 0; i < 18; i++) begin
      logic exp_we;
      int exp_a;
      exp_we = (i >= 8 && i < 16);
      exp_a = (i < 8) ? i : i - 8;
      n_tests += 2;
      if (acc_we[base+i] !== exp_we) begin n_fail++; $display("FAIL alt_we_l[%0d]: got %b want %b", i, acc_we[base+i], exp_we); end
      if (acc_addr[base+i] !== ADDR_W'(exp_a)) begin n_fail++; $display("FAIL alt_addr[%0d]: got %0d want %0d", i, acc_addr[base+i], exp_a); end
    end
    n_tests++;
    if (push_n - rb != 8) begin n_fail++; $display("FAIL alt_push_cnt: got %0d want 8", push_n - rb); end
    for (int j = 0; j < 8; j++) begin
      n_tests++;
      if (push_data[rb+j] !== 16'hA000 + 16'(j)) begin n_fail++; $display("FAIL alt_rd_data[%0d]: got %h want %h", j, push_data[rb+j], 16'hA000 + 16'(j)); end
    end
  endtask

  // Read last granted, yet an urgent read still beats a pending write.
  task automatic test_urgent();
    int base = acc_n;
    rd_level = 12'd1000;
    wait_acc(base + 1);
    n_tests += 2;
    if (rd_push !== 1'b1) begin n_fail++; $display("FAIL urg_push_timing: got %b want 1", rd_push); end
    if (rd_data !== 16'hA008) begin n_fail++; $display("FAIL urg_rd_data: got %h want a008", rd_data); end
    rd_level = 12'd4000;
    wait_idle();
    push_word(16'h7001);
    push_word(16'h7002);
    rd_level = 12'd100;
    wait_acc(base + 2);
    rd_level = 12'd4000;
    wait_acc(base + 4);
    wait_idle();
    n_tests += 8;
    if (acc_we[base] !== 1'b1 || acc_addr[base] !== 24'd8) begin n_fail++; $display("FAIL urg_first_read: got we_l=%b addr=%0d want we_l=1 addr=8", acc_we[base], acc_addr[base]); end
    if (acc_we[base+1] !== 1'b1) begin n_fail++; $display("FAIL urg_read_wins: we_l got %b want 1", acc_we[base+1]); end
    if (acc_addr[base+1] !== 24'd9) begin n_fail++; $display("FAIL urg_read_addr: got %0d want 9", acc_addr[base+1]); end
    if (acc_we[base+2] !== 1'b0) begin n_fail++; $display("FAIL urg_then_write: we_l got %b want 0", acc_we[base+2]); end
    if (acc_addr[base+2] !== 24'd10) begin n_fail++; $display("FAIL urg_wr_addr0: got %0d want 10", acc_addr[base+2]); end
    if (acc_addr[base+3] !== 24'd11) begin n_fail++; $display("FAIL urg_wr_addr1: got %0d want 11", acc_addr[base+3]); end
    if (acc_wd[base+3] !== 16'h7002) begin n_fail++; $display("FAIL urg_wr_data: got %h want 7002", acc_wd[base+3]); end
    if (push_data[push_n-1] !== 16'hA009) begin n_fail++; $display("FAIL urg_push_data: got %h want a009", push_data[push_n-1]); end
  endtask

  // SOF during the access at address 5: that access completes, next write and read go to 0.
  task automatic test_sof_mid();
    int base = acc_n;
    for (int i = 0; i < 7; i++) push_word(16'h8000 + 16'(i));
    wait_acc(base + 5);
    wait_sel();
    n_tests++;
    if (dram_addr !== 24'd5) begin n_fail++; $display("FAIL sof_pre_addr: got %0d want 5", dram_addr); end
    wr_sof = 1'b1; rd_sof = 1'b1;
    @(negedge clk);
    wr_sof = 1'b0; rd_sof = 1'b0;
    wait_acc(base + 7);
    wait_idle();
    rd_level = 12'd1000;
    wait_acc(base + 8);
    rd_level = 12'd4000;
    wait_idle();
    n_tests += 5;
    if (acc_addr[base+5] !== 24'd5) begin n_fail++; $display("FAIL sof_complete_addr: got %0d want 5", acc_addr[base+5]); end
    if (acc_wd[base+5] !== 16'h8005) begin n_fail++; $display("FAIL sof_complete_data: got %h want 8005", acc_wd[base+5]); end
    if (acc_addr[base+6] !== 24'd0) begin n_fail++; $display("FAIL sof_wr_restart: got %0d want 0", acc_addr[base+6]); end
    if (acc_wd[base+6] !== 16'h8006) begin n_fail++; $display("FAIL sof_wr_data: got %h want 8006", acc_wd[base+6]); end
    if (acc_we[base+7] !== 1'b1 || acc_addr[base+7] !== 24'd0) begin n_fail++; $display("FAIL sof_rd_restart: got we_l=%b addr=%0d want we_l=1 addr=0", acc_we[base+7], acc_addr[base+7]); end
  endtask

  // Reset with an access outstanding: bus idles at once and the write pointer restarts at 0.
  task automatic test_reset_mid();
    int base = acc_n;
    int pb = pop_cnt;
    push_word(16'h9001);
    push_word(16'h9002);
    wait_sel();
    n_tests++;
    if (dram_addr !== 24'd1) begin n_fail++; $display("FAIL rm_pre_addr: got %0d want 1", dram_addr); end
    reset = 1'b1;
    @(negedge clk);
    n_tests += 6;
    if (dram_sel_l !== 1'b1) begin n_fail++; $display("FAIL rm_sel_l: got %b want 1", dram_sel_l); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
    if (wr_pop !== 1'b0) begin n_fail++; $display("FAIL rm_wr_pop: got %b want 0", wr_pop); end
    if (rd_push !== 1'b0) begin n_fail++; $display("FAIL rm_rd_push: got %b want 0", rd_push); end
    if (dram_addr !== '0) begin n_fail++; $display("FAIL rm_addr: got %0d want 0", dram_addr); end
    if (pop_cnt != pb) begin n_fail++; $display("FAIL rm_no_pop: got %0d want 0", pop_cnt - pb); end
    reset = 1'b0;
    wait_acc(base + 2);
    wait_idle();
    n_tests += 3;
    if (acc_addr[base] !== 24'd0) begin n_fail++; $display("FAIL rm_restart_addr: got %0d want 0", acc_addr[base]); end
    if (acc_addr[base+1] !== 24'd1 || acc_wd[base+1] !== 16'h9002) begin n_fail++; $display("FAIL rm_second: got addr=%0d data=%h want addr=1 data=9002", acc_addr[base+1], acc_wd[base+1]); end
    if (pop_cnt - pb != 2) begin n_fail++; $display("FAIL rm_pops: got %0d want 2", pop_cnt - pb); end
  endtask

  initial begin
    test_reset();
    test_write_only();
    test_burst();
    test_alternate();
    test_urgent();
    test_sof_mid();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
